// File: rtl/calc_entry_sequencer.sv
// Operand-entry sequencer for the 4-bit arithmetic unit: A, op, B, execute, show.
// Optional running-total chaining from the result screen is enabled by defining CALC_CHAIN_EN.
module calc_entry_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_value,
    input  logic             btn_enter,
    input  logic             btn_add,
    input  logic             btn_sub,
    input  logic             btn_clear,
    input  logic [WIDTH-1:0] result_in,
    output logic [WIDTH-1:0] operand1,
    output logic [WIDTH-1:0] operand2,
    output logic             operation,
    output logic [WIDTH-1:0] result_q,
    output logic             result_valid,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] operand1_reg, operand1_next;
    logic [WIDTH-1:0] operand2_reg, operand2_next;
    logic             operation_reg, operation_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             valid_reg, valid_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_A;
            operand1_reg  <= '0;
            operand2_reg  <= '0;
            operation_reg <= 1'b0;
            result_reg    <= '0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            operand1_reg  <= operand1_next;
            operand2_reg  <= operand2_next;
            operation_reg <= operation_next;
            result_reg    <= result_next;
            valid_reg     <= valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        operand1_next  = operand1_reg;
        operand2_next  = operand2_reg;
        operation_next = operation_reg;
        result_next    = result_reg;
        valid_next     = valid_reg;

        // Clear and any illegal state code both collapse to the reset image.
        if (btn_clear) begin
            state_next     = S_A;
            operand1_next  = '0;
            operand2_next  = '0;
            operation_next = 1'b0;
            result_next    = '0;
            valid_next     = 1'b0;
        end else begin
            case (state_reg)
                S_A: begin
                    if (btn_enter) begin
                        operand1_next = sw_value;
                        state_next    = S_OP;
                    end
                end
                S_OP: begin
                    if (btn_add) begin
                        operation_next = 1'b1;
                        state_next     = S_B;
                    end else if (btn_sub) begin
                        operation_next = 1'b0;
                        state_next     = S_B;
                    end
                end
                S_B: begin
                    if (btn_enter) begin
                        operand2_next = sw_value;
                        state_next    = S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_next = result_in;
                    valid_next  = 1'b1;
                    state_next  = S_SHOW;
                end
                S_SHOW: begin
                    if (btn_enter) begin
                        valid_next = 1'b0;
                        state_next = S_A;
                    end
`ifdef CALC_CHAIN_EN
                    // Running total: the shown result becomes the next A operand.
                    else if (btn_add || btn_sub) begin
                        operand1_next  = result_reg;
                        operation_next = btn_add;
                        valid_next     = 1'b0;
                        state_next     = S_B;
                    end
`endif
                end
                default: begin
                    state_next     = S_A;
                    operand1_next  = '0;
                    operand2_next  = '0;
                    operation_next = 1'b0;
                    result_next    = '0;
                    valid_next     = 1'b0;
                end
            endcase
        end
    end

    assign operand1     = operand1_reg;
    assign operand2     = operand2_reg;
    assign operation    = operation_reg;
    assign result_q     = result_reg;
    assign result_valid = valid_reg;
    assign state_o      = state_reg;

endmodule
